// File: rtl/simplemem_pkg.sv
// Shared constants and state encoding for the CPU-side memory responder and boot loader.
package simplemem_pkg;

   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 9;
   localparam int unsigned DEPTH = 64;

   localparam logic [AW-1:0] LASTADDR = AW'(DEPTH - 1);
   localparam logic [DW-1:0] ZEROWORD = '0;

   typedef enum logic [1:0] {
      LOAD = 2'b00,
      FILL = 2'b01,
      RUN  = 2'b10
   } state_t;

endpackage

// File: rtl/memarray.sv
// Word RAM with one synchronous write port and an asynchronous read port; contents are not reset.
module memarray
   import simplemem_pkg::*;
(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/simplemem_loader.sv
// Memory responder for the CPU: boot-loads a program over a valid/ready port, zero-fills the rest,
// then serves CPU reads/writes while HOLD keeps the CPU parked during loading.
module simplemem_loader
   import simplemem_pkg::*;
(
   input  logic          clk,
   input  logic          CLR,
   input  logic          READ,
   input  logic          WRITE,
   input  logic [AW-1:0] A,
   input  logic [DW-1:0] DATA,
   output logic [DW-1:0] D,
   input  logic          LDVALID,
   input  logic [DW-1:0] LDDATA,
   input  logic          LDLAST,
   output logic          LDREADY,
   input  logic          RELOAD,
   output logic          HOLD,
   output logic          ERR
);

   state_t        state;
   logic [AW-1:0] ptr;
   logic          hold_q;
   logic          err_q;

   logic          in_load;
   logic          in_fill;
   logic          in_run;
   logic          accept;
   logic          cpu_wr;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   assign in_load = (state == LOAD);
   assign in_fill = (state == FILL);
   assign in_run  = (state == RUN);

   assign LDREADY = in_load && !CLR;
   assign accept  = LDREADY && LDVALID;
   // A simultaneous READ wins over WRITE so the conflicting write never lands.
   assign cpu_wr  = in_run && WRITE && !READ && !CLR;

   // Single write port shared by loader, zero-fill and CPU.
   always_comb begin
      we    = 1'b0;
      waddr = ptr;
      wdata = ZEROWORD;
      if (accept) begin
         we    = 1'b1;
         wdata = LDDATA;
      end else if (in_fill && !CLR) begin
         we    = 1'b1;
      end else if (cpu_wr) begin
         we    = 1'b1;
         waddr = A;
         wdata = DATA;
      end
   end

   memarray u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (A),
      .rdata (rdata)
   );

   assign D    = (in_run && READ && !CLR) ? rdata : ZEROWORD;
   assign HOLD = hold_q;
   assign ERR  = err_q;

   always_ff @(posedge clk) begin
      if (CLR) begin
         state  <= LOAD;
         ptr    <= '0;
         hold_q <= 1'b1;
         err_q  <= 1'b0;
      end else begin
         if ((!in_run && (READ || WRITE)) || (in_run && READ && WRITE)) begin
            err_q <= 1'b1;
         end
         case (state)
            LOAD: begin
               if (accept) begin
                  ptr <= ptr + AW'(1);
                  if (ptr == LASTADDR) begin
                     state  <= RUN;
                     hold_q <= 1'b0;
                  end else if (LDLAST) begin
                     state <= FILL;
                  end
               end
            end
            FILL: begin
               ptr <= ptr + AW'(1);
               if (ptr == LASTADDR) begin
                  state  <= RUN;
                  hold_q <= 1'b0;
               end
            end
            RUN: begin
               if (RELOAD) begin
                  state  <= LOAD;
                  ptr    <= '0;
                  hold_q <= 1'b1;
               end
            end
            default: begin
               state  <= LOAD;
               ptr    <= '0;
               hold_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simplemem_loader.sv
// Directed plus randomized bench for simplemem_loader against an array-based memory/loader model.
module tb_simplemem_loader;
   import simplemem_pkg::*;

   logic          clk = 1'b0;
   logic          CLR = 1'b1;
   logic          READ = 1'b0;
   logic          WRITE = 1'b0;
   logic [AW-1:0] A = '0;
   logic [DW-1:0] DATA = '0;
   logic [DW-1:0] D;
   logic          LDVALID = 1'b0;
   logic [DW-1:0] LDDATA = '0;
   logic          LDLAST = 1'b0;
   logic          LDREADY;
   logic          RELOAD = 1'b0;
   logic          HOLD;
   logic          ERR;

   simplemem_loader dut (
      .clk     (clk),
      .CLR     (CLR),
      .READ    (READ),
      .WRITE   (WRITE),
      .A       (A),
      .DATA    (DATA),
      .D       (D),
      .LDVALID (LDVALID),
      .LDDATA  (LDDATA),
      .LDLAST  (LDLAST),
      .LDREADY (LDREADY),
      .RELOAD  (RELOAD),
      .HOLD    (HOLD),
      .ERR     (ERR)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [8:0]  mdl [64];
   int          mdl_ptr = 0;
   bit          mdl_hold = 1'b1;
   bit          mdl_err = 1'b0;
   logic [8:0]  ld_q [$];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One CPU cycle: check the combinational D, apply the model at the edge, check sticky ERR.
   task automatic cpu_op(input bit rd, input bit wr, input int a, input logic [8:0] dat);
      logic [8:0] exp_d;
      READ  = rd;
      WRITE = wr;
      A     = AW'(a);
      DATA  = dat;
      #1;
      exp_d = (rd && !mdl_hold) ? mdl[a] : 9'h000;
      chk($sformatf("D@%0d", a), 16'(D), 16'(exp_d));
      if (mdl_hold) begin
         if (rd || wr) mdl_err = 1'b1;
      end else begin
         if (rd && wr) mdl_err = 1'b1;
         else if (wr) mdl[a] = dat;
      end
      tick();
      READ  = 1'b0;
      WRITE = 1'b0;
      chk("ERR", 16'(ERR), 16'(mdl_err));
   endtask

   // Streams ld_q through the load port, optionally with random LDVALID stalls.
   task automatic load_seq(input bit last, input bit stall);
      int n = ld_q.size();
      int accepted = 0;
      int guard = 0;
      bit acc;
      while (accepted < n && guard < 1000) begin
         guard++;
         LDVALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         LDDATA  = ld_q[accepted];
         LDLAST  = last && (accepted == n - 1);
         #1;
         chk("LDREADY_load", 16'(LDREADY), 16'h1);
         acc = LDVALID;
         tick();
         if (acc) begin
            mdl[mdl_ptr] = ld_q[accepted];
            mdl_ptr++;
            accepted++;
         end
      end
      LDVALID = 1'b0;
      LDLAST  = 1'b0;
      chk("load_accepts", 16'(accepted), 16'(n));
   endtask

   // Counts held cycles after the final load word; the model zero-fills the remaining words.
   task automatic wait_fill(input int exp_cycles);
      int cnt = 0;
      while (HOLD === 1'b1 && cnt < 200) begin
         if (cnt == 0) chk("LDREADY_fill", 16'(LDREADY), 16'h0);
         cnt++;
         tick();
      end
      chk("fill_cycles", 16'(cnt), 16'(exp_cycles));
      for (int i = mdl_ptr; i < 64; i++) mdl[i] = 9'h000;
      mdl_ptr  = 0;
      mdl_hold = 1'b0;
      chk("HOLD_run", 16'(HOLD), 16'h0);
   endtask

   task automatic read_rand(input int n);
      for (int i = 0; i < n; i++) cpu_op(1'b1, 1'b0, int'($urandom_range(0, 63)), 9'h000);
   endtask

   initial begin
      // Reset, checked while CLR is still asserted.
      READ = 1'b1;
      tick();
      chk("rst_LDREADY", 16'(LDREADY), 16'h0);
      chk("rst_HOLD", 16'(HOLD), 16'h1);
      chk("rst_D", 16'(D), 16'h0);
      chk("rst_ERR", 16'(ERR), 16'h0);
      READ = 1'b0;
      CLR  = 1'b0;
      #1;
      chk("LDREADY_after_rst", 16'(LDREADY), 16'h1);

      // Short program with LDLAST, then 61 fill cycles.
      ld_q = '{9'h040, 9'h1C5, 9'h0FF};
      load_seq(1'b1, 1'b0);
      wait_fill(61);
      cpu_op(1'b1, 1'b0, 1, 9'h000);
      cpu_op(1'b1, 1'b0, 10, 9'h000);
      cpu_op(1'b1, 1'b0, 0, 9'h000);

      // CPU write then read-back; idle read port returns zero.
      cpu_op(1'b0, 1'b1, 5, 9'h123);
      cpu_op(1'b1, 1'b0, 5, 9'h000);
      cpu_op(1'b0, 1'b0, 5, 9'h000);

      // Random CPU traffic with stray LDVALID, which must be ignored in RUN.
      for (int i = 0; i < 80; i++) begin
         bit rd = 1'($urandom_range(0, 1));
         LDVALID = 1'($urandom_range(0, 1));
         LDDATA  = 9'($urandom);
         LDLAST  = 1'($urandom_range(0, 1));
         cpu_op(rd, !rd, int'($urandom_range(0, 63)), 9'($urandom));
      end
      LDVALID = 1'b0;
      LDLAST  = 1'b0;

      // Conflicting READ+WRITE: read wins, write dropped, ERR sticks.
      cpu_op(1'b1, 1'b1, 2, 9'h1FF);
      cpu_op(1'b1, 1'b0, 2, 9'h000);
      cpu_op(1'b0, 1'b0, 0, 9'h000);

      // RELOAD with a coincident write that must still land.
      RELOAD = 1'b1;
      WRITE  = 1'b1;
      A      = AW'(7);
      DATA   = 9'h0AA;
      mdl[7] = 9'h0AA;
      tick();
      RELOAD = 1'b0;
      WRITE  = 1'b0;
      mdl_hold = 1'b1;
      mdl_ptr  = 0;
      chk("reload_HOLD", 16'(HOLD), 16'h1);
      chk("reload_LDREADY", 16'(LDREADY), 16'h1);
      cpu_op(1'b1, 1'b0, 7, 9'h000);

      // Full 64-word load with stalls: no fill, straight to RUN.
      ld_q.delete();
      for (int i = 0; i < 64; i++) ld_q.push_back(9'(i));
      load_seq(1'b0, 1'b1);
      wait_fill(0);
      cpu_op(1'b1, 1'b0, 63, 9'h000);
      read_rand(12);

      // CLR clears ERR; CLR mid-load keeps HOLD and drops LDREADY for that cycle.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      mdl_err  = 1'b0;
      mdl_hold = 1'b1;
      mdl_ptr  = 0;
      chk("clr_ERR", 16'(ERR), 16'h0);
      ld_q.delete();
      for (int i = 0; i < 10; i++) ld_q.push_back(9'($urandom));
      load_seq(1'b0, 1'b1);
      CLR = 1'b1;
      #1;
      chk("clr_mid_LDREADY", 16'(LDREADY), 16'h0);
      chk("clr_mid_HOLD", 16'(HOLD), 16'h1);
      tick();
      CLR = 1'b0;
      mdl_ptr = 0;
      #1;
      chk("clr_mid_HOLD_after", 16'(HOLD), 16'h1);
      ld_q = '{9'h155, 9'h0AB};
      load_seq(1'b1, 1'b0);
      wait_fill(62);
      cpu_op(1'b1, 1'b0, 0, 9'h000);
      cpu_op(1'b1, 1'b0, 1, 9'h000);
      cpu_op(1'b1, 1'b0, 5, 9'h000);
      read_rand(8);

      // RELOAD then a READ while held: D stays zero, ERR rises.
      RELOAD = 1'b1;
      tick();
      RELOAD = 1'b0;
      mdl_hold = 1'b1;
      mdl_ptr  = 0;
      chk("reload2_HOLD", 16'(HOLD), 16'h1);
      chk("reload2_LDREADY", 16'(LDREADY), 16'h1);
      chk("reload2_ERR_pre", 16'(ERR), 16'h0);
      cpu_op(1'b1, 1'b0, 1, 9'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
